rpn_sequencer: RTL and testbench
================================

# rpn_sequencer

Upstream token sequencer for the RPN stack calculator core. Holds a small program of RPN tokens loaded over a valid/ready port and, on `start`, replays it into the core by driving the core's `push`, `op`, `d` and `step` inputs one token at a time. Tracks a shadow stack depth, seeded from the core's `cnt`, so that an underflowing or overflowing token halts the run with an error instead of being silently dropped by the core. On completion it captures the core's top-of-stack as `result`.

## Interface
- `PROG_DEPTH`, 64: program buffer capacity in tokens; power of two.
- `clk  in  1`: single clock; all state changes on rising edge.
- `nrst  in  1`: asynchronous active-low reset.
- `ld_valid  in  1`: token offered on `ld_token`.
- `ld_token  in  18`: [17:16] kind (0 PUSH, 1 NEG, 2 ADD, 3 MUL); [15:0] PUSH value, ignored otherwise.
- `ld_ready  out  1`: token accepted when `ld_valid && ld_ready` at a clock edge.
- `prog_clr  in  1`: empties program buffer (IDLE only).
- `start  in  1`: run program from token 0 (IDLE only).
- `rpn_cnt  in  10`: core stack depth.
- `rpn_out  in  16`: core top-of-stack.
- `rpn_step  out  1`: registered step strobe to core.
- `rpn_push  out  1`, `rpn_op  out  2`, `rpn_d  out  16`: registered token fields to core.
- `busy  out  1`, `done  out  1`, `err  out  1`: run status.
- `err_pc  out  $clog2(PROG_DEPTH)`: index of the rejected token.
- `result  out  16`: captured top-of-stack.
- `prog_len  out  $clog2(PROG_DEPTH)+1`: tokens loaded.

## Operation
- States: IDLE, ISSUE, STROBE, FINISH.
- IDLE: `ld_ready = !start && prog_len < PROG_DEPTH`. Accepted token written at index `prog_len`, `prog_len` increments. `prog_clr` sets `prog_len` to 0 (takes priority over load). `start` clears `done`, `err`, loads `pc=0`, `depth=rpn_cnt`; goes to ISSUE if `prog_len>0`, else to FINISH.
- ISSUE (token at `pc`): legality check on shadow `depth`: PUSH needs depth<1023, NEG needs depth≥1, ADD/MUL need depth≥2.
  - Illegal: no strobe, `err=1`, `err_pc=pc`, back to IDLE; `result` unchanged.
  - Legal: drive `rpn_push=1, rpn_op=0, rpn_d=value` for PUSH; `rpn_push=0, rpn_op=kind, rpn_d=0` otherwise; go to STROBE.
- STROBE: `rpn_step=1`, fields held; depth +1 (PUSH), -1 (ADD/MUL), unchanged (NEG). If `pc==prog_len-1` go to FINISH, else `pc+1`, ISSUE.
- FINISH: `rpn_step=0`, fields return to idle values; at exit edge `result<=rpn_out`, `done=1`, go to IDLE.
- Idle field values: `rpn_push=0, rpn_op=0, rpn_d=0, rpn_step=0` (op 0 is a core no-op).
- `busy=1` in ISSUE, STROBE, FINISH. `done`/`err` sticky until next `start`, `prog_clr` does not clear them.
- `start` outside IDLE ignored; `prog_clr` outside IDLE ignored; program buffer read-only while busy.

## Timing
- Reset: state IDLE; all outputs 0 except `ld_ready=1`; `prog_len=0`; buffer contents undefined.
- `nrst` mid-run: immediate return to reset values; `rpn_step` drops asynchronously; program lost.
- Fields become valid one cycle before `rpn_step` rises; stay stable through the strobe cycle, so core captures on `rpn_step` rising edge with full setup.
- N-token run, `start` sampled at edge 0: `busy` from cycle 1, token k strobe in cycle 2k+2, FINISH in cycle 2N+1, `done=1` and `result` valid from cycle 2N+2.
- Empty program: `done=1` at cycle 2, `result=rpn_out`.
- Error on token k: `err=1`, `busy=0` from cycle 2k+2; exactly k strobes issued.
- `start` and `ld_valid` in same IDLE cycle: load refused (`ld_ready=0`), run uses existing program.

## Test plan
- Core empty; load PUSH 3, PUSH 4, ADD, PUSH 5, MUL; start -> 5 single-cycle `rpn_step` pulses, field order matches, `done` at cycle 12, `result=35`, core cnt 1.
- Load PUSH 7, NEG; start -> `result=16'hFFF9`, `done` at cycle 6, `err=0`.
- `rpn_cnt=0`; program ADD; start -> no `rpn_step`, `err=1`, `err_pc=0`, `busy=0` at cycle 2.
- Load 64 tokens -> `prog_len=64`, `ld_ready=0`, 65th offer not accepted; `prog_clr` -> `prog_len=0`, `ld_ready=1`.
- Assert `nrst` low after 3rd strobe -> all outputs 0 immediately, `prog_len=0`, no further strobes after release.
- `start` pulsed while `busy` -> ignored, run completes unchanged; `start` with `prog_len=0` -> `done` at cycle 2, zero strobes.

Source files
------------

// File: rtl/rpn_sequencer.sv
// rpn_sequencer
// Holds a small program of RPN tokens and replays it into the RPN stack
// calculator core, one token per ISSUE/STROBE pair. A shadow copy of the
// core's stack depth lets the sequencer stop with an error on a token that
// would underflow or overflow, instead of letting the core silently drop it.
//
// Ports
//   clk, nrst            clock, asynchronous active-low reset
//   ld_valid/ld_token    program load port; ld_ready back-pressures it
//   prog_clr             empty the program buffer (IDLE only)
//   start                run the program from token 0 (IDLE only)
//   rpn_cnt, rpn_out     core stack depth and top-of-stack
//   rpn_step             registered single-cycle step strobe to the core
//   rpn_push/op/d        registered token fields to the core
//   busy, done, err      run status; done/err sticky until the next start
//   err_pc               index of the token that was refused
//   result               core top-of-stack captured when a run completes
//   prog_len             number of tokens currently loaded
//   dbg_state            current FSM state (IDLE=0 ISSUE=1 STROBE=2 FINISH=3)
//
// Load handshake: a token transfers on every rising edge where
// ld_valid && ld_ready. ld_valid may be raised at any time and the token
// must be held until the transfer; ld_ready may fall without a transfer
// (buffer full, start requested, or a run in progress).

module rpn_sequencer #(
    parameter int PROG_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          ld_valid,
    input  logic [17:0]                   ld_token,
    output logic                          ld_ready,
    input  logic                          prog_clr,
    input  logic                          start,
    input  logic [9:0]                    rpn_cnt,
    input  logic [15:0]                   rpn_out,
    output logic                          rpn_step,
    output logic                          rpn_push,
    output logic [1:0]                    rpn_op,
    output logic [15:0]                   rpn_d,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [$clog2(PROG_DEPTH)-1:0] err_pc,
    output logic [15:0]                   result,
    output logic [$clog2(PROG_DEPTH):0]   prog_len,
    output logic [1:0]                    dbg_state
);

    localparam int AW = $clog2(PROG_DEPTH);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(PROG_DEPTH);

    localparam logic [1:0] K_PUSH = 2'd0;
    localparam logic [1:0] K_NEG  = 2'd1;
    localparam logic [1:0] K_ADD  = 2'd2;
    localparam logic [1:0] K_MUL  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_STROBE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    logic [17:0]   prog_mem [PROG_DEPTH];

    state_t        state_q;
    logic [AW-1:0] pc_q;
    logic [AW:0]   len_q;
    logic [9:0]    depth_q;
    logic          legal_q;
    logic          step_q;
    logic          push_q;
    logic [1:0]    op_q;
    logic [15:0]   d_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [AW-1:0] err_pc_q;
    logic [15:0]   result_q;

    logic [AW-1:0] issue_idx;
    logic [17:0]   issue_tok;
    logic [9:0]    issue_depth;
    logic          issue_legal;
    logic [1:0]    cur_kind;
    logic [9:0]    depth_d;
    logic          f_push;
    logic [1:0]    f_op;
    logic [15:0]   f_d;
    logic          is_last;
    logic          ld_ready_c;
    logic          load_fire;

    function automatic logic tok_legal(input logic [1:0] kind, input logic [9:0] depth);
        logic ok;
        case (kind)
            K_PUSH:  ok = (depth != 10'h3FF);
            K_NEG:   ok = (depth != 10'd0);
            default: ok = (depth >= 10'd2);
        endcase
        return ok;
    endfunction

    // The token about to enter ISSUE is decoded one edge early, so its
    // fields are already on the core port for the whole ISSUE cycle and the
    // strobe that follows sees them with a full cycle of setup. Its legality
    // is judged against the depth it will see: rpn_cnt when leaving IDLE,
    // otherwise the depth after the token currently being strobed.
    always_comb begin
        issue_idx = (state_q == S_IDLE) ? '0 : pc_q + 1'b1;
        issue_tok = prog_mem[issue_idx];
        cur_kind  = prog_mem[pc_q][17:16];

        depth_d = depth_q;
        case (cur_kind)
            K_PUSH:       depth_d = depth_q + 10'd1;
            K_ADD, K_MUL: depth_d = depth_q - 10'd1;
            default:      ;
        endcase

        issue_depth = (state_q == S_IDLE) ? rpn_cnt : depth_d;
        issue_legal = tok_legal(issue_tok[17:16], issue_depth);

        f_push = 1'b0;
        f_op   = 2'd0;
        f_d    = 16'd0;
        if (issue_legal) begin
            if (issue_tok[17:16] == K_PUSH) begin
                f_push = 1'b1;
                f_d    = issue_tok[15:0];
            end else begin
                f_op = issue_tok[17:16];
            end
        end

        is_last    = ({1'b0, pc_q} == (len_q - 1'b1));
        ld_ready_c = (state_q == S_IDLE) && !start && (len_q < LEN_MAX);
        // prog_clr wins over a load offered in the same cycle
        load_fire  = ld_valid && ld_ready_c && !prog_clr;
    end

    // Program storage has no reset; prog_len alone says what is valid.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            prog_mem[len_q[AW-1:0]] <= ld_token;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            depth_q  <= '0;
            legal_q  <= 1'b0;
            step_q   <= 1'b0;
            push_q   <= 1'b0;
            op_q     <= 2'd0;
            d_q      <= 16'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            err_pc_q <= '0;
            result_q <= 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        pc_q    <= '0;
                        depth_q <= rpn_cnt;
                        busy_q  <= 1'b1;
                        if (len_q != '0) begin
                            state_q <= S_ISSUE;
                            legal_q <= issue_legal;
                            push_q  <= f_push;
                            op_q    <= f_op;
                            d_q     <= f_d;
                        end else begin
                            state_q <= S_FINISH;
                        end
                    end else if (prog_clr) begin
                        len_q <= '0;
                    end else if (load_fire) begin
                        len_q <= len_q + 1'b1;
                    end
                end

                S_ISSUE: begin
                    if (legal_q) begin
                        step_q  <= 1'b1;
                        state_q <= S_STROBE;
                    end else begin
                        // refused token: no strobe, result keeps its old value
                        err_q    <= 1'b1;
                        err_pc_q <= pc_q;
                        busy_q   <= 1'b0;
                        push_q   <= 1'b0;
                        op_q     <= 2'd0;
                        d_q      <= 16'd0;
                        state_q  <= S_IDLE;
                    end
                end

                S_STROBE: begin
                    step_q  <= 1'b0;
                    depth_q <= depth_d;
                    if (is_last) begin
                        push_q  <= 1'b0;
                        op_q    <= 2'd0;
                        d_q     <= 16'd0;
                        state_q <= S_FINISH;
                    end else begin
                        pc_q    <= pc_q + 1'b1;
                        legal_q <= issue_legal;
                        push_q  <= f_push;
                        op_q    <= f_op;
                        d_q     <= f_d;
                        state_q <= S_ISSUE;
                    end
                end

                S_FINISH: begin
                    // the core has absorbed the last strobe by now
                    result_q <= rpn_out;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ld_ready  = ld_ready_c;
    assign rpn_step  = step_q;
    assign rpn_push  = push_q;
    assign rpn_op    = op_q;
    assign rpn_d     = d_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_pc    = err_pc_q;
    assign result    = result_q;
    assign prog_len  = len_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Testbench for rpn_sequencer. Contains a behavioural model of the RPN core
// (stack of up to 1023 entries) driven by the sequencer's step/field
// outputs, a strobe monitor that pops expected token fields from exp_q, and
// one task per scenario.

module tb_rpn_sequencer;

    logic        clk;
    logic        nrst;
    logic        ld_valid;
    logic [17:0] ld_token;
    logic        ld_ready;
    logic        prog_clr;
    logic        start;
    logic [9:0]  rpn_cnt;
    logic [15:0] rpn_out;
    logic        rpn_step;
    logic        rpn_push;
    logic [1:0]  rpn_op;
    logic [15:0] rpn_d;
    logic        busy;
    logic        done;
    logic        err;
    logic [5:0]  err_pc;
    logic [15:0] result;
    logic [6:0]  prog_len;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;

    logic [18:0] exp_q[$];
    logic [17:0] tb_prog[$];
    logic [15:0] last_res;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    rpn_sequencer #(.PROG_DEPTH(64)) dut (
        .clk(clk), .nrst(nrst), .ld_valid(ld_valid), .ld_token(ld_token),
        .ld_ready(ld_ready), .prog_clr(prog_clr), .start(start),
        .rpn_cnt(rpn_cnt), .rpn_out(rpn_out), .rpn_step(rpn_step),
        .rpn_push(rpn_push), .rpn_op(rpn_op), .rpn_d(rpn_d), .busy(busy),
        .done(done), .err(err), .err_pc(err_pc), .result(result),
        .prog_len(prog_len), .dbg_state(dbg_state)
    );

    // ---------------- core model ----------------
    logic        core_clr;
    logic [9:0]  core_cnt;
    logic [15:0] stk [1024];

    always @(posedge clk) begin
        if (core_clr) begin
            core_cnt <= 10'd0;
        end else if (rpn_step) begin
            if (rpn_push) begin
                if (core_cnt != 10'h3FF) begin
                    stk[core_cnt] <= rpn_d;
                    core_cnt      <= core_cnt + 10'd1;
                end
            end else begin
                case (rpn_op)
                    2'd1: if (core_cnt >= 1) stk[core_cnt-1] <= 16'(16'd0 - stk[core_cnt-1]);
                    2'd2: if (core_cnt >= 2) begin
                        stk[core_cnt-2] <= stk[core_cnt-2] + stk[core_cnt-1];
                        core_cnt        <= core_cnt - 10'd1;
                    end
                    2'd3: if (core_cnt >= 2) begin
                        stk[core_cnt-2] <= 16'(stk[core_cnt-2] * stk[core_cnt-1]);
                        core_cnt        <= core_cnt - 10'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rpn_cnt = core_cnt;
    assign rpn_out = (core_cnt != 10'd0) ? stk[core_cnt-1] : 16'h0000;

    // ---------------- scoreboard / strobe monitor ----------------
    logic        prev_step;
    logic [18:0] prev_fields;
    logic [18:0] mon_w;

    initial begin
        prev_step   = 1'b0;
        prev_fields = '0;
        forever begin
            @(negedge clk);
            if (nrst && rpn_step) begin
                strobe_cnt++;
                checks++;
                if (prev_step !== 1'b0) begin
                    errors++;
                    $display("FAIL strobe_width: step high two cycles running, got %b want 0", prev_step);
                end
                checks++;
                if ({rpn_push, rpn_op, rpn_d} !== prev_fields) begin
                    errors++;
                    $display("FAIL field_setup: fields at strobe %h, cycle before %h", {rpn_push, rpn_op, rpn_d}, prev_fields);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got fields %h, want no strobe", {rpn_push, rpn_op, rpn_d});
                end else begin
                    mon_w = exp_q.pop_front();
                    if ({rpn_push, rpn_op, rpn_d} !== mon_w) begin
                        errors++;
                        $display("FAIL strobe_fields: got %h want %h", {rpn_push, rpn_op, rpn_d}, mon_w);
                    end
                end
            end
            prev_step   = rpn_step;
            prev_fields = {rpn_push, rpn_op, rpn_d};
        end
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    // ---------------- helpers ----------------
    function automatic logic [18:0] tok_fields(input logic [17:0] t);
        if (t[17:16] == 2'd0) return {1'b1, 2'd0, t[15:0]};
        return {1'b0, t[17:16], 16'h0000};
    endfunction

    function automatic logic [15:0] eval_prog();
        logic [15:0] s[$];
        logic [15:0] a, b;
        foreach (tb_prog[i]) begin
            case (tb_prog[i][17:16])
                2'd0: s.push_back(tb_prog[i][15:0]);
                2'd1: begin a = s.pop_back(); s.push_back(16'(16'd0 - a)); end
                2'd2: begin a = s.pop_back(); b = s.pop_back(); s.push_back(16'(b + a)); end
                default: begin a = s.pop_back(); b = s.pop_back(); s.push_back(16'(b * a)); end
            endcase
        end
        return (s.size() > 0) ? s[s.size()-1] : 16'h0000;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        nrst = 1'b0; core_clr = 1'b1; start = 1'b0; prog_clr = 1'b0;
        ld_valid = 1'b0; ld_token = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1; core_clr = 1'b0;
        tb_prog.delete();
        exp_q.delete();
        last_res = 16'h0000;
        @(posedge clk); #1;
    endtask

    task automatic core_clear();
        @(negedge clk); core_clr = 1'b1;
        @(posedge clk); #1 core_clr = 1'b0;
    endtask

    task automatic clear_prog();
        @(negedge clk); prog_clr = 1'b1;
        @(posedge clk); #1 prog_clr = 1'b0;
        tb_prog.delete();
    endtask

    task automatic load_tok(input logic [1:0] kind, input logic [15:0] val);
        @(negedge clk);
        ld_valid = 1'b1; ld_token = {kind, val};
        @(posedge clk); #1 ld_valid = 1'b0;
        tb_prog.push_back({kind, val});
    endtask

    // poke: 0 plain run, 1 pulse start while busy, 2 offer a load with start
    task automatic run_prog(input string name, input bit clear_core, input int poke);
        logic [9:0]  dep;
        logic [1:0]  kd;
        logic [15:0] want_res;
        bit          ok;
        int n, err_k, cyc, s0, want_cyc, want_str;
        if (clear_core) core_clear();
        n = tb_prog.size(); dep = core_cnt; err_k = -1;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            kd = tb_prog[k][17:16];
            case (kd)
                2'd0:    ok = (dep != 10'd1023);
                2'd1:    ok = (dep >= 10'd1);
                default: ok = (dep >= 10'd2);
            endcase
            if (!ok) begin err_k = k; break; end
            exp_q.push_back(tok_fields(tb_prog[k]));
            if (kd == 2'd0) dep = dep + 10'd1;
            else if (kd != 2'd1) dep = dep - 10'd1;
        end
        if (err_k >= 0) begin
            want_res = last_res; want_cyc = 2*err_k + 2; want_str = err_k;
        end else begin
            want_res = (n == 0) ? rpn_out : eval_prog(); want_cyc = 2*n + 2; want_str = n;
        end
        s0 = strobe_cnt;

        @(negedge clk); start = 1'b1;
        if (poke == 2) begin
            ld_valid = 1'b1; ld_token = {2'd0, 16'hDEAD};
            #1; checks++;
            if (ld_ready !== 1'b0) begin
                errors++; $display("FAIL %s ld_ready_with_start: got %b want 0", name, ld_ready);
            end
        end
        @(posedge clk); #1; start = 1'b0; ld_valid = 1'b0; cyc = 1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_cycle1: got %b want 1", name, busy); end
        while (!(done || err) && cyc < 400) begin
            start = (poke == 1) && (cyc == 3 || cyc == 4);
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0;

        checks++;
        if (cyc != want_cyc) begin errors++; $display("FAIL %s end_cycle: got %0d want %0d", name, cyc, want_cyc); end
        checks++;
        if (done !== (err_k < 0)) begin errors++; $display("FAIL %s done: got %b want %b", name, done, err_k < 0); end
        checks++;
        if (err !== (err_k >= 0)) begin errors++; $display("FAIL %s err: got %b want %b", name, err, err_k >= 0); end
        if (err_k >= 0) begin
            checks++;
            if (err_pc !== 6'(err_k)) begin errors++; $display("FAIL %s err_pc: got %0d want %0d", name, err_pc, err_k); end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_end: got %b want 0", name, busy); end
        checks++;
        if (strobe_cnt - s0 != want_str) begin errors++; $display("FAIL %s strobes: got %0d want %0d", name, strobe_cnt - s0, want_str); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL %s missing_strobes: got %0d left want 0", name, exp_q.size()); end
        checks++;
        if (result !== want_res) begin errors++; $display("FAIL %s result: got %h want %h", name, result, want_res); end
        checks++;
        if (prog_len !== 7'(n)) begin errors++; $display("FAIL %s prog_len: got %0d want %0d", name, prog_len, n); end
        checks++;
        if ({rpn_step, rpn_push, rpn_op, rpn_d} !== 20'h0) begin
            errors++; $display("FAIL %s idle_fields: got %h want 0", name, {rpn_step, rpn_push, rpn_op, rpn_d});
        end
        last_res = want_res;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset ld_ready: got %b want 1", ld_ready); end
        checks++;
        if ({rpn_step, rpn_push, rpn_op, rpn_d} !== 20'h0) begin
            errors++; $display("FAIL reset fields: got %h want 0", {rpn_step, rpn_push, rpn_op, rpn_d});
        end
        checks++;
        if ({busy, done, err, err_pc} !== 9'h0) begin
            errors++; $display("FAIL reset status: got %h want 0", {busy, done, err, err_pc});
        end
        checks++;
        if ({result, prog_len, dbg_state} !== 25'h0) begin
            errors++; $display("FAIL reset result_len_state: got %h want 0", {result, prog_len, dbg_state});
        end
    endtask

    task automatic test_basic();
        clear_prog();
        load_tok(2'd0, 16'd3); load_tok(2'd0, 16'd4); load_tok(2'd2, 16'd0);
        load_tok(2'd0, 16'd5); load_tok(2'd3, 16'd0);
        run_prog("basic", 1'b1, 0);
        checks++;
        if (result !== 16'd35) begin errors++; $display("FAIL basic result35: got %0d want 35", result); end
        checks++;
        if (core_cnt !== 10'd1) begin errors++; $display("FAIL basic core_cnt: got %0d want 1", core_cnt); end
    endtask

    task automatic test_neg();
        clear_prog();
        load_tok(2'd0, 16'd7); load_tok(2'd1, 16'h1234);
        run_prog("neg", 1'b1, 0);
        checks++;
        if (result !== 16'hFFF9) begin errors++; $display("FAIL neg resultFFF9: got %h want fff9", result); end
    endtask

    task automatic test_underflow();
        clear_prog();
        load_tok(2'd2, 16'd0);
        run_prog("underflow_first", 1'b1, 0);
        clear_prog();
        load_tok(2'd0, 16'd1); load_tok(2'd2, 16'd0); load_tok(2'd0, 16'd9);
        run_prog("underflow_second", 1'b1, 0);
        clear_prog();
        load_tok(2'd1, 16'd0);
        run_prog("neg_empty", 1'b1, 0);
    endtask

    task automatic test_full();
        clear_prog();
        for (int i = 0; i < 64; i++) load_tok(2'd0, 16'(i));
        checks++;
        if (prog_len !== 7'd64) begin errors++; $display("FAIL full prog_len: got %0d want 64", prog_len); end
        checks++;
        if (ld_ready !== 1'b0) begin errors++; $display("FAIL full ld_ready: got %b want 0", ld_ready); end
        @(negedge clk); ld_valid = 1'b1; ld_token = {2'd0, 16'hBEEF};
        repeat (3) @(posedge clk);
        #1 ld_valid = 1'b0;
        checks++;
        if (prog_len !== 7'd64) begin errors++; $display("FAIL full overflow_offer: got %0d want 64", prog_len); end
        run_prog("full_run", 1'b1, 0);
        clear_prog();
        checks++;
        if (prog_len !== 7'd0) begin errors++; $display("FAIL full clr_len: got %0d want 0", prog_len); end
        checks++;
        if (ld_ready !== 1'b1) begin errors++; $display("FAIL full clr_ready: got %b want 1", ld_ready); end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL full done_sticky: got %b want 1", done); end
    endtask

    task automatic test_start_busy();
        clear_prog();
        load_tok(2'd0, 16'd3); load_tok(2'd0, 16'd4); load_tok(2'd2, 16'd0);
        load_tok(2'd0, 16'd5); load_tok(2'd3, 16'd0);
        run_prog("start_while_busy", 1'b1, 1);
        run_prog("start_with_load", 1'b1, 2);
        clear_prog();
        run_prog("empty", 1'b0, 0);
    endtask

    task automatic test_reset_mid_run();
        int s0;
        clear_prog();
        for (int i = 0; i < 6; i++) load_tok(2'd0, 16'(100 + i));
        core_clear();
        exp_q.delete();
        foreach (tb_prog[i]) exp_q.push_back(tok_fields(tb_prog[i]));
        s0 = strobe_cnt;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #2;
            if (strobe_cnt - s0 == 3) break;
        end
        checks++;
        if (strobe_cnt - s0 != 3 || rpn_step !== 1'b1) begin
            errors++; $display("FAIL midrst third_strobe: got %0d strobes step %b want 3 and 1", strobe_cnt - s0, rpn_step);
        end
        nrst = 1'b0;
        #1;
        checks++;
        if ({rpn_step, rpn_push, rpn_op, rpn_d, busy, done, err} !== 23'h0) begin
            errors++; $display("FAIL midrst outputs: got %h want 0", {rpn_step, rpn_push, rpn_op, rpn_d, busy, done, err});
        end
        checks++;
        if (prog_len !== 7'd0 || ld_ready !== 1'b1) begin
            errors++; $display("FAIL midrst len_ready: got %0d/%b want 0/1", prog_len, ld_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); nrst = 1'b1;
        exp_q.delete(); tb_prog.delete(); last_res = 16'h0000;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (strobe_cnt - s0 != 3) begin errors++; $display("FAIL midrst no_more_strobes: got %0d want 3", strobe_cnt - s0); end
        checks++;
        if (busy !== 1'b0 || result !== 16'h0) begin
            errors++; $display("FAIL midrst after_release: busy %b result %h want 0/0", busy, result);
        end
    endtask

    task automatic test_random();
        int n, dep;
        logic [1:0] kd;
        for (int it = 0; it < 4; it++) begin
            clear_prog();
            n = $urandom_range(3, 12); dep = 0;
            for (int k = 0; k < n; k++) begin
                if (dep == 0)      kd = 2'd0;
                else if (dep == 1) kd = 2'($urandom_range(0, 1));
                else               kd = 2'($urandom_range(0, 3));
                load_tok(kd, 16'($urandom_range(0, 65535)));
                if (kd == 2'd0) dep++; else if (kd != 2'd1) dep--;
            end
            run_prog("random", 1'b1, 0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_neg();
        test_underflow();
        test_full();
        test_start_busy();
        test_reset_mid_run();
        test_random();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
